// File: rtl/spike_vote_classifier.sv
// spike_vote_classifier: per-class rising-edge spike counters with a frame-end argmax vote
module spike_vote_classifier #(
  parameter int N_CLASS  = 10,
  parameter int CNT_W    = 3,
  parameter int SATURATE = 1,
  parameter int AUTO_CLR = 1,
  localparam int IDX_W   = N_CLASS > 1 ? $clog2(N_CLASS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_s,
  input  logic [N_CLASS-1:0]       spike,
  input  logic                     clr,
  input  logic                     frame_end,
  output logic [N_CLASS*CNT_W-1:0] counts,
  output logic                     busy,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [IDX_W-1:0]         res_class,
  output logic [CNT_W-1:0]         res_count
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state_q, state_d;
  logic [N_CLASS-1:0] d1, d2, inc;
  logic [CNT_W-1:0] cnt [N_CLASS];
  logic [CNT_W-1:0] snap [N_CLASS];
  logic [IDX_W-1:0] idx, best_idx, nb_idx;
  logic [CNT_W-1:0] best_cnt, nb_cnt;
  logic start, last, gt;
  assign inc   = d1 & ~d2;
  assign start = state_q == IDLE && frame_end;
  assign last  = idx == IDX_W'(N_CLASS - 1);
  // strict compare keeps the lowest index on ties
  assign gt     = snap[idx] > best_cnt;
  assign nb_cnt = gt ? snap[idx] : best_cnt;
  assign nb_idx = gt ? idx : best_idx;
  assign busy      = state_q != IDLE;
  assign res_valid = state_q == DONE;
  for (genvar i = 0; i < N_CLASS; i++) begin : g_out
    assign counts[i*CNT_W +: CNT_W] = cnt[i];
  end
  always_comb begin
    state_d = state_q == IDLE ? (frame_end ? SCAN : IDLE) :
              state_q == SCAN ? (last ? DONE : SCAN) :
              (res_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d1 <= '0;
      d2 <= '0;
      for (int i = 0; i < N_CLASS; i++) cnt[i] <= '0;
    end else begin
      d1 <= en_s ? spike : '0;
      d2 <= d1;
      for (int i = 0; i < N_CLASS; i++)
        cnt[i] <= clr ? '0 :
                  (start && AUTO_CLR != 0) ? CNT_W'(inc[i]) :
                  !inc[i] ? cnt[i] :
                  (SATURATE != 0 && &cnt[i]) ? cnt[i] : cnt[i] + CNT_W'(1);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx       <= '0;
      best_idx  <= '0;
      best_cnt  <= '0;
      res_class <= '0;
      res_count <= '0;
      for (int i = 0; i < N_CLASS; i++) snap[i] <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        for (int i = 0; i < N_CLASS; i++) snap[i] <= cnt[i];
        idx      <= '0;
        best_idx <= '0;
        best_cnt <= '0;
      end else if (state_q == SCAN) begin
        idx      <= idx + IDX_W'(1);
        best_idx <= nb_idx;
        best_cnt <= nb_cnt;
        if (last) begin
          res_class <= nb_idx;
          res_count <= nb_cnt;
        end
      end
    end
  end
endmodule

// File: tb/tb_spike_vote_classifier.sv
// tb_spike_vote_classifier: scoreboard bench for the spike vote classifier (saturating and wrapping instances)
module tb_spike_vote_classifier;
  localparam int NC = 10;
  localparam int CW = 3;
  localparam int IW = 4;
  logic clk = 0, rst = 1, en_s = 0, clr = 0, frame_end = 0, res_ready = 0;
  logic [NC-1:0] spike = '0;
  logic [NC*CW-1:0] counts, counts_w;
  logic busy, res_valid, busy_w, res_valid_w;
  logic [IW-1:0] res_class, res_class_w;
  logic [CW-1:0] res_count, res_count_w;
  int n_cmp = 0, n_bad = 0;
  int ec [NC];
  int lat;
  logic [IW+CW-1:0] sb [$];
  logic [IW+CW-1:0] e;

  spike_vote_classifier dut (
    .clk(clk), .rst(rst), .en_s(en_s), .spike(spike), .clr(clr), .frame_end(frame_end),
    .counts(counts), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_class(res_class), .res_count(res_count));

  spike_vote_classifier #(.SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .en_s(en_s), .spike(spike), .clr(clr), .frame_end(frame_end),
    .counts(counts_w), .busy(busy_w), .res_valid(res_valid_w), .res_ready(res_ready),
    .res_class(res_class_w), .res_count(res_count_w));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int c, input int n);
    repeat (n) begin
      spike[c] = 1'b1;
      tick();
      spike[c] = 1'b0;
      tick();
    end
  endtask

  task automatic fire();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!res_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic clear_exp();
    foreach (ec[i]) ec[i] = 0;
  endtask

  function automatic logic [NC*CW-1:0] packed_exp();
    logic [NC*CW-1:0] r = '0;
    for (int i = 0; i < NC; i++) r[i*CW +: CW] = CW'(ec[i]);
    return r;
  endfunction

  task automatic push_vote();
    int bi = 0, bc = 0;
    for (int i = 0; i < NC; i++)
      if (ec[i] > bc) begin
        bc = ec[i];
        bi = i;
      end
    sb.push_back({IW'(bi), CW'(bc)});
  endtask

  always @(negedge clk)
    if (!rst && res_valid && res_ready) begin
      check("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("res_class", res_class, e[IW+CW-1:CW]);
        check("res_count", res_count, e[CW-1:0]);
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) tick();
    check("rst_counts", counts, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", res_valid, 0);
    check("rst_class", res_class, 0);
    check("rst_count", res_count, 0);
    rst = 0;
    tick();
    // held level counts once, visible after the second edge
    en_s = 1;
    spike[3] = 1;
    tick();
    check("t1_edge1", counts, 0);
    tick();
    clear_exp();
    ec[3] = 1;
    check("t1_edge2", counts, packed_exp());
    repeat (3) tick();
    spike[3] = 0;
    repeat (2) tick();
    check("t1_held", counts, packed_exp());
    check("t1_held_w", counts_w, packed_exp());
    // saturate vs wrap
    clr = 1;
    tick();
    clr = 0;
    check("t2_clr", counts, 0);
    pulse(2, 9);
    check("t2_sat", counts[2*CW +: CW], 7);
    check("t2_wrap", counts_w[2*CW +: CW], 1);
    // gating and clear priority
    clr = 1;
    tick();
    clr = 0;
    en_s = 0;
    pulse(1, 3);
    check("t3_gated", counts, 0);
    en_s = 1;
    spike[1] = 1;
    tick();
    spike[1] = 0;
    clr = 1;
    tick();
    clr = 0;
    check("t3_clr_wins", counts, 0);
    spike[4] = 1;
    repeat (2) tick();
    check("t3_held1", counts[4*CW +: CW], 1);
    clr = 1;
    tick();
    clr = 0;
    repeat (2) tick();
    check("t3_no_recount", counts, 0);
    spike[4] = 0;
    tick();
    // vote with tie, auto-clear with same-cycle edge
    pulse(1, 4);
    pulse(5, 6);
    pulse(7, 6);
    clear_exp();
    ec[1] = 4;
    ec[5] = 6;
    ec[7] = 6;
    check("t4_pre", counts, packed_exp());
    push_vote();
    spike[0] = 1;
    tick();
    spike[0] = 0;
    fire();
    clear_exp();
    ec[0] = 1;
    check("t4_autoclr", counts, packed_exp());
    check("t4_busy", busy, 1);
    check("t4_valid_lo", res_valid, 0);
    wait_valid(lat);
    check("t4_latency", lat, 10);
    check("t4_valid_w", res_valid_w, 1);
    check("t4_class_w", res_class_w, 5);
    check("t4_count_w", res_count_w, 6);
    // back-pressure; frame_end in DONE ignored
    repeat (5) tick();
    pulse(6, 1);
    fire();
    repeat (11) tick();
    ec[6] = 1;
    check("t5_valid_held", res_valid, 1);
    check("t5_class_held", res_class, 5);
    check("t5_count_held", res_count, 6);
    check("t5_no_clear", counts, packed_exp());
    res_ready = 1;
    tick();
    check("t5_valid_drop", res_valid, 0);
    check("t5_idle", busy, 0);
    check("t5_class_kept", res_class, 5);
    repeat (12) tick();
    check("t5_not_queued", res_valid, 0);
    // reset mid-scan
    clr = 1;
    tick();
    clr = 0;
    pulse(2, 3);
    fire();
    repeat (3) tick();
    check("t6_busy_pre", busy, 1);
    #2 rst = 1;
    #1;
    check("t6_busy", busy, 0);
    check("t6_valid", res_valid, 0);
    check("t6_counts", counts, 0);
    check("t6_class", res_class, 0);
    check("t6_counts_w", counts_w, 0);
    check("t6_busy_w", busy_w, 0);
    tick();
    rst = 0;
    tick();
    pulse(8, 2);
    pulse(3, 2);
    clear_exp();
    ec[8] = 2;
    ec[3] = 2;
    push_vote();
    fire();
    wait_valid(lat);
    check("t6_latency", lat, 10);
    tick();
    // all-zero snapshot
    clr = 1;
    tick();
    clr = 0;
    clear_exp();
    push_vote();
    fire();
    wait_valid(lat);
    check("t7_latency", lat, 10);
    repeat (3) tick();
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
